// File: rtl/narvie_uart_pkg.sv
// Shared UART constants and byte-FSM state encoding for the narvie bridge.
package narvie_uart_pkg;
    localparam int CLK_HZ_DEFAULT = 12_000_000;
    localparam int B9600          = 9_600;
    localparam int B57600         = 57_600;
    localparam int B115200        = 115_200;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_START = 2'd1;
    localparam rx_state_t ST_DATA  = 2'd2;
    localparam rx_state_t ST_STOP  = 2'd3;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM, stop-bit check.
module uart_rx_byte
    import narvie_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       idle
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rxs;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;

    assign idle = (state == ST_IDLE);

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rxs        <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // rx_meta is the next value of rxs: this catches the 1->0 fall of rxs
                    // on the very edge it happens, keeping the sample points early.
                    if (rxs && !rx_meta) begin
                        state <= ST_START;
                        cnt   <= HALF;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        if (!rxs) begin
                            state   <= ST_DATA;
                            cnt     <= FULL;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        byte_data <= {rxs, byte_data[7:1]};
                        cnt       <= FULL;
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        // Back to IDLE at mid-stop so a back-to-back start edge is never missed.
                        state <= ST_IDLE;
                        if (rxs) byte_valid <= 1'b1;
                        else     frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_instruction.sv
// Assembles four received UART bytes into a 32-bit instruction word with an inter-byte timeout.
module uart_rx_instruction
    import narvie_uart_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int BAUD         = B115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk12,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] instruction,
    output logic        instruction_rcv,
    output logic        frame_err,
    output logic        busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TO_LIMIT + 1);

    logic [7:0]  byte_data;
    logic        byte_valid, rx_idle, timeout;
    logic [1:0]  byte_idx;
    logic [23:0] hold;
    logic [TW-1:0] to_cnt;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk12      (clk12),
        .rst        (rst),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .idle       (rx_idle)
    );

    assign timeout = (to_cnt == TW'(TO_LIMIT));
    assign busy    = !rx_idle || (byte_idx != 2'd0);

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            instruction     <= NOP_INSTR;
            instruction_rcv <= 1'b0;
            byte_idx        <= '0;
            hold            <= '0;
            to_cnt          <= '0;
        end else begin
            instruction_rcv <= 1'b0;
            if (byte_valid) begin
                case (byte_idx)
                    2'd0: hold[7:0]   <= byte_data;
                    2'd1: hold[15:8]  <= byte_data;
                    2'd2: hold[23:16] <= byte_data;
                    default: begin
                        instruction     <= {byte_data, hold};
                        instruction_rcv <= 1'b1;
                    end
                endcase
                byte_idx <= byte_idx + 1'b1;
            end else if (frame_err || timeout) begin
                byte_idx <= '0;
            end
            // Gap timer only runs between bytes of a partial word; any frame activity resets it.
            if (!rx_idle || byte_idx == 2'd0 || timeout) to_cnt <= '0;
            else                                          to_cnt <= to_cnt + 1'b1;
        end
    end
endmodule
